// File: rtl/stack_seq_pkg.sv
// ============================================================================
//  stack_seq_pkg : token op codes, FSM state encoding and op-class helper
//  Revision      : 1.0
// ============================================================================
`default_nettype none

package stack_seq_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP_A  = 2'd1,
    ST_POP_B  = 2'd2,
    ST_PUSH_R = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_alu.sv
// ============================================================================
//  stack_alu : combinational binary operator, a = second entry, b = top entry
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module stack_alu
  import stack_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
// ============================================================================
//  stack_seq : RPN token sequencer driving a load/push/pop hardware stack
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [W-1:0]  in_data,
  output logic          stk_load,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_d,
  input  logic [W-1:0]  stk_qtop,
  input  logic [W-1:0]  stk_qnext,
  output logic [DW-1:0] depth,
  output logic          done,
  output logic          err
);

  localparam logic [DW-1:0] C_FULL = DW'(DEPTH);

  state_t        state_q, state_d;
  logic [W-1:0]  res_q, res_d;
  logic          alu_q, alu_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [W-1:0]  alu_y;
  logic          accept;
  logic          bad_tok;

  stack_alu #(.W(W)) u_alu (
    .op_i (in_op),
    .a_i  (stk_qnext),
    .b_i  (stk_qtop),
    .y_o  (alu_y)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // Boundary check is made against the depth seen at accept time.
  always_comb begin
    bad_tok = 1'b0;
    case (in_op)
      OP_PUSH: bad_tok = (depth_q == C_FULL);
      OP_DUP:  bad_tok = (depth_q == C_FULL) || (depth_q == '0);
      OP_POP:  bad_tok = (depth_q == '0);
      default: bad_tok = is_alu_op(in_op) && (depth_q < DW'(2));
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    alu_d    = alu_q;
    depth_d  = depth_q;
    err_d    = err_q;
    done_d   = 1'b0;
    stk_load = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_tok) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            case (in_op)
              OP_PUSH: begin
                res_d   = in_data;
                state_d = ST_PUSH_R;
              end
              OP_DUP: begin
                res_d   = stk_qtop;
                state_d = ST_PUSH_R;
              end
              OP_POP: begin
                alu_d   = 1'b0;
                state_d = ST_POP_B;
              end
              default: begin
                res_d   = alu_y;
                alu_d   = 1'b1;
                state_d = ST_POP_A;
              end
            endcase
          end
        end
      end
      ST_POP_A: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DW'(1);
        state_d = ST_POP_B;
      end
      ST_POP_B: begin
        stk_pop = 1'b1;
        depth_d = depth_q - DW'(1);
        if (alu_q) begin
          state_d = ST_PUSH_R;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_PUSH_R: begin
        stk_load = 1'b1;
        stk_push = 1'b1;
        depth_d  = depth_q + DW'(1);
        state_d  = ST_IDLE;
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      alu_q   <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      alu_q   <= alu_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign stk_d = res_q;
  assign depth = depth_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

`default_nettype wire
